// File: rtl/program_sequencer.sv
// Multi-cycle control sequencer for the single-datapath core: owns the PC and walks each
// instruction through FETCH, EXEC, optional MEM_WAIT and WB, halting on Ack or memory timeout.

module program_sequencer_checker (
    input logic Clk,
    input logic Reset,
    input logic Busy,
    input logic Done,
    input logic Err,
    input logic MemReq,
    input logic MemWe
);

    // Structural invariants between the decoded outputs
    always @(posedge Clk) begin
        if (!Reset) begin
            assert (!(Done && Busy));
            assert (!MemWe || MemReq);
            assert (!Err || Done);
        end
    end

endmodule

module program_sequencer #(
    parameter int PC_W        = 10,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             BranchEn,
    input  logic [1:0]       TargSel,
    input  logic             LoadInst,
    input  logic             MemWrEn,
    input  logic             RegWrEn,
    input  logic             Ack,
    input  logic             Zero,
    input  logic [PC_W-1:0]  LutTarget,
    input  logic             MemDone,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             InstrLd,
    output logic             RegWrStrobe,
    output logic             MemReq,
    output logic             MemWe,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [CNT_W-1:0] CycleCount
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_WB       = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              zero_q_r;
    logic              err_r;
    logic              cond_s;
    logic              taken_s;
    logic              busy_s;
    logic              start_acc_s;
    logic              timeout_s;

    // Start is only honoured while stopped; a running program ignores it
    assign start_acc_s = ((state_r == ST_IDLE) || (state_r == ST_HALT)) && Start;
    assign busy_s      = (state_r == ST_FETCH) || (state_r == ST_EXEC) ||
                         (state_r == ST_MEM_WAIT) || (state_r == ST_WB);
    assign timeout_s   = (state_r == ST_MEM_WAIT) && !MemDone && (wait_cnt_r == WAIT_LAST);

    // Branch condition from the zero flag captured during EXEC; select 11 is reserved
    always_comb begin
        cond_s = 1'b0;
        case (TargSel)
            2'b00:   cond_s = 1'b1;
            2'b01:   cond_s = zero_q_r;
            2'b10:   cond_s = ~zero_q_r;
            default: cond_s = 1'b0;
        endcase
        taken_s = BranchEn & cond_s;
        if (taken_s) begin
            pc_next_s = LutTarget;
        end else begin
            pc_next_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) state_s = ST_FETCH;
                else       state_s = ST_IDLE;
            end
            ST_FETCH: state_s = ST_EXEC;
            ST_EXEC: begin
                if (Ack)                     state_s = ST_HALT;
                else if (LoadInst | MemWrEn) state_s = ST_MEM_WAIT;
                else                         state_s = ST_WB;
            end
            ST_MEM_WAIT: begin
                if (MemDone)        state_s = ST_WB;
                else if (timeout_s) state_s = ST_HALT;
                else                state_s = ST_MEM_WAIT;
            end
            ST_WB: state_s = ST_FETCH;
            ST_HALT: begin
                if (Start) state_s = ST_FETCH;
                else       state_s = ST_HALT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Program counter: cleared on Start, advanced only on WB exit
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                 pc_r <= {PC_W{1'b0}};
        else if (start_acc_s)      pc_r <= {PC_W{1'b0}};
        else if (state_r == ST_WB) pc_r <= pc_next_s;
        else                       pc_r <= pc_r;
    end

    // Saturating run-cycle counter, frozen while stopped
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                                 cnt_r <= {CNT_W{1'b0}};
        else if (start_acc_s)                      cnt_r <= {CNT_W{1'b0}};
        else if (busy_s && (cnt_r != {CNT_W{1'b1}})) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        else                                       cnt_r <= cnt_r;
    end

    // Zero flag latch for the WB branch decision
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                   zero_q_r <= 1'b0;
        else if (state_r == ST_EXEC) zero_q_r <= Zero;
        else                         zero_q_r <= zero_q_r;
    end

    // Memory wait counter; restarted each time EXEC dispatches
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                   wait_cnt_r <= {WAIT_W{1'b0}};
        else if (state_r == ST_EXEC) wait_cnt_r <= {WAIT_W{1'b0}};
        else if ((state_r == ST_MEM_WAIT) && !MemDone && (wait_cnt_r != WAIT_LAST))
                                     wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        else                         wait_cnt_r <= wait_cnt_r;
    end

    // Error flag: set entering HALT on timeout, held until the next Start
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)            err_r <= 1'b0;
        else if (start_acc_s) err_r <= 1'b0;
        else if (timeout_s)   err_r <= 1'b1;
        else                  err_r <= err_r;
    end

    assign ProgCtr     = pc_r;
    assign CycleCount  = cnt_r;
    assign InstrLd     = (state_r == ST_FETCH);
    assign RegWrStrobe = (state_r == ST_WB) & RegWrEn;
    assign MemReq      = (state_r == ST_MEM_WAIT);
    assign MemWe       = (state_r == ST_MEM_WAIT) & MemWrEn;
    assign Busy        = busy_s;
    assign Done        = (state_r == ST_HALT);
    assign Err         = err_r;

    program_sequencer_checker u_checker (
        .Clk    (Clk),
        .Reset  (Reset),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err),
        .MemReq (MemReq),
        .MemWe  (MemWe)
    );

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: ALU, branch, load/store, timeout, wrap, halt and reset cases.

module tb_program_sequencer;

    logic       Clk = 1'b0;
    logic       Reset, Start, BranchEn, LoadInst, MemWrEn, RegWrEn, Ack, Zero, MemDone;
    logic [1:0] TargSel;
    logic [9:0] LutTarget;
    logic [9:0] ProgCtr;
    logic       InstrLd, RegWrStrobe, MemReq, MemWe, Busy, Done, Err;
    logic [15:0] CycleCount;

    logic [9:0] pc_small;
    logic       ld_small, str_small, req_small, we_small, busy_small, done_small, err_small;
    logic [3:0] cnt_small;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    program_sequencer #(.PC_W(10), .CNT_W(16), .MEM_TIMEOUT(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BranchEn(BranchEn), .TargSel(TargSel),
        .LoadInst(LoadInst), .MemWrEn(MemWrEn), .RegWrEn(RegWrEn), .Ack(Ack), .Zero(Zero),
        .LutTarget(LutTarget), .MemDone(MemDone), .ProgCtr(ProgCtr), .InstrLd(InstrLd),
        .RegWrStrobe(RegWrStrobe), .MemReq(MemReq), .MemWe(MemWe), .Busy(Busy), .Done(Done),
        .Err(Err), .CycleCount(CycleCount)
    );

    program_sequencer #(.PC_W(10), .CNT_W(4), .MEM_TIMEOUT(16)) dut_small (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BranchEn(BranchEn), .TargSel(TargSel),
        .LoadInst(LoadInst), .MemWrEn(MemWrEn), .RegWrEn(RegWrEn), .Ack(Ack), .Zero(Zero),
        .LutTarget(LutTarget), .MemDone(MemDone), .ProgCtr(pc_small), .InstrLd(ld_small),
        .RegWrStrobe(str_small), .MemReq(req_small), .MemWe(we_small), .Busy(busy_small),
        .Done(done_small), .Err(err_small), .CycleCount(cnt_small)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Called while in FETCH; runs one non-memory instruction and lands in the next FETCH
    task automatic run_alu(input string tag, input logic br, input logic [1:0] sel, input logic z,
                           input logic [9:0] tgt, input logic rw, input logic [9:0] exp_pc);
        BranchEn = br; TargSel = sel; Zero = z; LutTarget = tgt; RegWrEn = rw;
        LoadInst = 1'b0; MemWrEn = 1'b0; Ack = 1'b0; MemDone = 1'b0;
        tick();
        check({tag, ":exec_str"}, 32'(RegWrStrobe), 32'd0);
        tick();
        check({tag, ":wb_str"}, 32'(RegWrStrobe), 32'(rw));
        tick();
        check({tag, ":pc"}, 32'(ProgCtr), 32'(exp_pc));
        check({tag, ":instr_ld"}, 32'(InstrLd), 32'd1);
    endtask

    // Called while in FETCH; done_at = MEM_WAIT cycle index carrying MemDone (0 = never)
    task automatic mem_op(input string tag, input logic ld, input logic st, input logic rw,
                          input int done_at, input int exp_req, input logic exp_we,
                          input int exp_str, input int exp_len);
        int n_req = 0;
        int n_str = 0;
        int len = 0;
        logic we_seen = 1'b0;
        BranchEn = 1'b0; TargSel = 2'b00; Ack = 1'b0; Zero = 1'b0;
        LoadInst = ld; MemWrEn = st; RegWrEn = rw; MemDone = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            len++;
            if (MemReq) begin
                n_req++;
                we_seen = we_seen | MemWe;
                MemDone = (n_req == done_at);
            end else begin
                MemDone = 1'b0;
            end
            if (RegWrStrobe) n_str++;
            if (InstrLd || Done) break;
        end
        MemDone = 1'b0; LoadInst = 1'b0; MemWrEn = 1'b0;
        check({tag, ":req_cycles"}, 32'(n_req), 32'(exp_req));
        check({tag, ":we"}, 32'(we_seen), 32'(exp_we));
        check({tag, ":strobes"}, 32'(n_str), 32'(exp_str));
        check({tag, ":length"}, 32'(len), 32'(exp_len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] cnt_hold;
        Reset = 1'b1; Start = 1'b0; BranchEn = 1'b0; TargSel = 2'b00; LoadInst = 1'b0;
        MemWrEn = 1'b0; RegWrEn = 1'b0; Ack = 1'b0; Zero = 1'b0; MemDone = 1'b0;
        LutTarget = 10'd0;
        #12;
        check("rst:pc", 32'(ProgCtr), 32'd0);
        check("rst:busy", 32'(Busy), 32'd0);
        check("rst:done", 32'(Done), 32'd0);
        check("rst:err", 32'(Err), 32'd0);
        check("rst:cnt", 32'(CycleCount), 32'd0);
        check("rst:instr_ld", 32'(InstrLd), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        check("idle:busy", 32'(Busy), 32'd0);

        // T1: single ALU op with register write
        RegWrEn = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        check("t1:fetch_ld", 32'(InstrLd), 32'd1);
        check("t1:fetch_busy", 32'(Busy), 32'd1);
        check("t1:fetch_str", 32'(RegWrStrobe), 32'd0);
        tick();
        check("t1:exec_ld", 32'(InstrLd), 32'd0);
        check("t1:exec_str", 32'(RegWrStrobe), 32'd0);
        tick();
        check("t1:wb_str", 32'(RegWrStrobe), 32'd1);
        check("t1:wb_pc", 32'(ProgCtr), 32'd0);
        tick();
        check("t1:pc", 32'(ProgCtr), 32'd1);
        check("t1:cnt", 32'(CycleCount), 32'd3);
        check("t1:next_ld", 32'(InstrLd), 32'd1);

        // T2: conditional branches
        run_alu("br_z1", 1'b1, 2'b01, 1'b1, 10'h2A, 1'b0, 10'h2A);
        run_alu("br_z0", 1'b1, 2'b01, 1'b0, 10'h2A, 1'b0, 10'h2B);
        run_alu("br_rsv", 1'b1, 2'b11, 1'b1, 10'h2A, 1'b0, 10'h2C);
        Start = 1'b1;
        run_alu("br_nz", 1'b1, 2'b10, 1'b0, 10'h2A, 1'b0, 10'h2A);
        Start = 1'b0;

        // T5: PC wrap and counter saturation in the narrow-counter instance
        run_alu("br_max", 1'b1, 2'b00, 1'b1, 10'h3FF, 1'b1, 10'h3FF);
        run_alu("wrap", 1'b0, 2'b00, 1'b0, 10'h000, 1'b1, 10'h000);
        check("t5:cnt", 32'(CycleCount), 32'd21);
        check("t5:cnt_sat", 32'(cnt_small), 32'd15);

        // T3: load with MemDone on 4th wait cycle, then single-cycle store
        mem_op("load", 1'b1, 1'b0, 1'b1, 4, 4, 1'b0, 1, 7);
        check("load:pc", 32'(ProgCtr), 32'd1);
        mem_op("store", 1'b0, 1'b1, 1'b0, 1, 1, 1'b1, 0, 4);
        check("store:pc", 32'(ProgCtr), 32'd2);

        // T4: memory timeout
        mem_op("tmo", 1'b1, 1'b0, 1'b1, 0, 16, 1'b0, 0, 18);
        check("tmo:err", 32'(Err), 32'd1);
        check("tmo:done", 32'(Done), 32'd1);
        check("tmo:busy", 32'(Busy), 32'd0);
        check("tmo:pc", 32'(ProgCtr), 32'd2);
        tick();
        check("tmo:err_hold", 32'(Err), 32'd1);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("restart:err", 32'(Err), 32'd0);
        check("restart:pc", 32'(ProgCtr), 32'd0);
        check("restart:done", 32'(Done), 32'd0);
        check("restart:ld", 32'(InstrLd), 32'd1);

        // T6: Ack at PC 5
        for (int i = 1; i <= 5; i++) begin
            run_alu("step", 1'b0, 2'b00, 1'b0, 10'h000, 1'b1, 10'(i));
        end
        Ack = 1'b1; RegWrEn = 1'b1;
        tick();
        check("ack:exec_str", 32'(RegWrStrobe), 32'd0);
        tick();
        check("ack:done", 32'(Done), 32'd1);
        check("ack:pc", 32'(ProgCtr), 32'd5);
        check("ack:err", 32'(Err), 32'd0);
        check("ack:str", 32'(RegWrStrobe), 32'd0);
        cnt_hold = CycleCount;
        tick();
        tick();
        check("ack:cnt_frozen", 32'(CycleCount), 32'(cnt_hold));
        Ack = 1'b0; RegWrEn = 1'b0;

        // Reset asserted off-edge during MEM_WAIT
        Start = 1'b1;
        tick();
        Start = 1'b0;
        run_alu("pre", 1'b0, 2'b00, 1'b0, 10'h000, 1'b0, 10'd1);
        LoadInst = 1'b1; MemDone = 1'b0;
        tick();
        tick();
        check("mrst:req_before", 32'(MemReq), 32'd1);
        #3;
        Reset = 1'b1;
        #1;
        check("mrst:req", 32'(MemReq), 32'd0);
        check("mrst:busy", 32'(Busy), 32'd0);
        check("mrst:pc", 32'(ProgCtr), 32'd0);
        check("mrst:cnt", 32'(CycleCount), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        LoadInst = 1'b0;
        tick();
        check("mrst:idle_busy", 32'(Busy), 32'd0);
        check("mrst:idle_ld", 32'(InstrLd), 32'd0);
        check("mrst:idle_done", 32'(Done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
